// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: word-organised buffer with byte/halfword/word
// access, programmable wait states and the two-cycle ERROR response.
module ahb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                  IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH*4);
  localparam logic [2:0]          WS_LOAD    = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [2:0]            wait_cnt;
  logic [2:0]            wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  can_accept;
  logic                  accept;
  logic                  illegal;
  logic [3:0]            lane_en;
  logic [IDX_W-1:0]      idx_q;
  logic                  unused_ok;

  assign idx_q     = addr_q[IDX_W+1:2];
  assign unused_ok = ^{HBURST, HTRANS[0], addr_q[ADDR_WIDTH-1:IDX_W+2]};

  // Legality of the transfer currently on the address bus
  always_comb begin
    illegal = 1'b0;
    if (HSIZE > 3'b010)
      illegal = 1'b1;
    if ((HSIZE == 3'b001) && HADDR[0])
      illegal = 1'b1;
    if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
      illegal = 1'b1;
    if ({1'b0, HADDR} >= ADDR_LIMIT)
      illegal = 1'b1;
  end

  // Next state, wait counter and response outputs
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    HREADYOUT    = 1'b1;
    HRESP        = 1'b0;
    can_accept   = 1'b0;
    case (state)
      ST_IDLE:   can_accept = 1'b1;
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt <= 3'd1) begin
          state_nxt    = ST_ACCESS;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt - 3'd1;
        end
      end
      ST_ACCESS: can_accept = 1'b1;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP      = 1'b1;
        can_accept = 1'b1;
      end
      default:   state_nxt = ST_IDLE;
    endcase

    accept = can_accept & HSEL & HTRANS[1] & HREADY;

    // IDLE, ACCESS and ERR2 share the address-phase decision
    if (can_accept) begin
      if (!accept) begin
        state_nxt = ST_IDLE;
      end else if (illegal) begin
        state_nxt = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = WS_LOAD;
      end else begin
        state_nxt = ST_ACCESS;
      end
    end
  end

  // Byte lanes touched by the captured transfer
  always_comb begin
    lane_en = '0;
    case (size_q)
      3'b000:  lane_en = 4'b0001 << addr_q[1:0];
      3'b001:  lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = '1;
    endcase
  end

  // Read data only during a read ACCESS
  always_comb begin
    HRDATA = '0;
    if ((state == ST_ACCESS) && !write_q)
      HRDATA = mem[idx_q];
  end

  // Control state and address-phase capture
  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // Write commit at the edge closing ACCESS; reset drops it
  always_ff @(posedge HCLK) begin
    if (!RESET && (state == ST_ACCESS) && write_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i])
          mem[idx_q][i*8 +: 8] <= HWDATA[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (0 and 2 wait states) on a shared
// pipelined AHB master, checked against a byte-lane memory model.
module tb_ahb_mem_slave;

  logic        HCLK = 1'b0;
  logic        RESET;
  logic        hsel_bus;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        dut_sel;

  logic        hsel0, hsel2;
  logic        rdy0, rdy2, resp0, resp2;
  logic [31:0] rdata0, rdata2;
  logic        hready_bus, hresp_bus;
  logic [31:0] hrdata_bus;

  assign hsel0      = hsel_bus & ~dut_sel;
  assign hsel2      = hsel_bus & dut_sel;
  assign hready_bus = dut_sel ? rdy2 : rdy0;
  assign hresp_bus  = dut_sel ? resp2 : resp0;
  assign hrdata_bus = dut_sel ? rdata2 : rdata0;

  always #5 HCLK = ~HCLK;

  ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(64), .WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .RESET(RESET), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready_bus), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(64), .WAIT_STATES(2)) u2 (
    .HCLK(HCLK), .RESET(RESET), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready_bus), .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2)
  );

  // transfer list
  logic [15:0] t_addr  [64];
  logic        t_write [64];
  logic [2:0]  t_size  [64];
  logic [31:0] t_wdata [64];
  logic [1:0]  t_trans [64];
  logic        t_sel   [64];
  // observations
  int          ob_waits     [64];
  logic        ob_resp_lo   [64];
  logic        ob_resp_hi   [64];
  logic [31:0] ob_rdata     [64];
  int          ob_acc_edge  [64];
  int          ob_done_edge [64];
  // expectations
  int          e_waits [64];
  logic        e_resp  [64];
  logic [31:0] e_rdata [64];

  logic [31:0] mdl [2][64];

  int errors = 0;
  int checks = 0;

  function automatic logic m_illegal(input logic [15:0] addr, input logic [2:0] size);
    int unsigned a = addr;
    int unsigned nb;
    if (size > 3'd2) return 1'b1;
    nb = 1 << size;
    return ((a % nb) != 0) || (a >= 256);
  endfunction

  task automatic m_write(input int ds, input logic [15:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata);
    int unsigned a  = addr;
    int unsigned w  = a / 4;
    int unsigned nb = 1 << size;
    for (int unsigned b = 0; b < nb; b++) begin
      int unsigned lane = (a % 4) + b;
      mdl[ds][w][lane*8 +: 8] = wdata[lane*8 +: 8];
    end
  endtask

  // Walk the transfer list in order, producing per-beat expectations
  task automatic compute_exp(input int n, input int ds);
    int ws = (ds == 1) ? 2 : 0;
    for (int i = 0; i < n; i++) begin
      if (!t_sel[i]) begin
        e_waits[i] = 0; e_resp[i] = 1'b0; e_rdata[i] = '0;
      end else if (m_illegal(t_addr[i], t_size[i])) begin
        e_waits[i] = 1; e_resp[i] = 1'b1; e_rdata[i] = '0;
      end else begin
        e_waits[i] = ws; e_resp[i] = 1'b0;
        if (t_write[i]) begin
          e_rdata[i] = '0;
          m_write(ds, t_addr[i], t_size[i], t_wdata[i]);
        end else begin
          e_rdata[i] = mdl[ds][int'(t_addr[i]) / 4];
        end
      end
    end
  endtask

  task automatic set_tr(input int i, input logic sel, input logic [15:0] addr,
                        input logic wr, input logic [2:0] size, input logic [31:0] wd,
                        input logic [1:0] tr);
    t_sel[i] = sel; t_addr[i] = addr; t_write[i] = wr;
    t_size[i] = size; t_wdata[i] = wd; t_trans[i] = tr;
  endtask

  task automatic present(input int a, input int n);
    if (a < n) begin
      hsel_bus = t_sel[a]; haddr = t_addr[a]; htrans = t_trans[a];
      hwrite = t_write[a]; hsize = t_size[a]; hburst = 3'b001;
    end else begin
      hsel_bus = 1'b0; haddr = '0; htrans = 2'b00;
      hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000;
    end
  endtask

  // Pipelined master: called and returns #1 after a rising edge
  task automatic run_bus(input int n);
    int   a = 0;
    int   d = -1;
    int   guard = 0;
    int   ecount = 0;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      ob_waits[i] = 0; ob_resp_lo[i] = 1'b0; ob_resp_hi[i] = 1'b0; ob_rdata[i] = '0;
      ob_acc_edge[i] = 0; ob_done_edge[i] = 0;
    end
    present(a, n);
    while ((a < n || d >= 0) && guard < 400) begin
      @(negedge HCLK);
      rdy = hready_bus;
      if (d >= 0) begin
        if (!rdy) begin
          ob_waits[d]++;
          ob_resp_lo[d] = ob_resp_lo[d] | hresp_bus;
        end else begin
          ob_resp_hi[d] = hresp_bus;
          ob_rdata[d]   = hrdata_bus;
        end
      end
      @(posedge HCLK);
      ecount++;
      if (rdy) begin
        if (d >= 0) ob_done_edge[d] = ecount;
        if (a < n) begin
          ob_acc_edge[a] = ecount;
          d = a;
          a++;
        end else begin
          d = -1;
        end
      end
      #1;
      if (rdy && d >= 0) hwdata = t_wdata[d];
      present(a, n);
      guard++;
    end
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: got %0d cycles, required under 400", guard);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    dut_sel = 1'b0;
    hwdata = '0;
    present(0, 0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    checks += 6;
    if (rdy0 !== 1'b1)     begin errors++; $display("FAIL reset_ready0: got %b, required 1", rdy0); end
    if (resp0 !== 1'b0)    begin errors++; $display("FAIL reset_resp0: got %b, required 0", resp0); end
    if (rdata0 !== 32'h0)  begin errors++; $display("FAIL reset_rdata0: got %h, required 0", rdata0); end
    if (rdy2 !== 1'b1)     begin errors++; $display("FAIL reset_ready2: got %b, required 1", rdy2); end
    if (resp2 !== 1'b0)    begin errors++; $display("FAIL reset_resp2: got %b, required 0", resp2); end
    if (rdata2 !== 32'h0)  begin errors++; $display("FAIL reset_rdata2: got %h, required 0", rdata2); end
    @(posedge HCLK); #1;
    RESET = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_fill(input int ds);
    dut_sel = ds[0];
    for (int i = 0; i < 64; i++)
      set_tr(i, 1'b1, 16'(i * 4), 1'b1, 3'b010, $urandom, (i == 0) ? 2'b10 : 2'b11);
    compute_exp(64, ds);
    run_bus(64);
    for (int i = 0; i < 64; i++) begin
      checks += 2;
      if (ob_waits[i] !== e_waits[i]) begin errors++; $display("FAIL fill%0d_waits beat %0d: got %0d, required %0d", ds, i, ob_waits[i], e_waits[i]); end
      if (ob_resp_hi[i] !== e_resp[i]) begin errors++; $display("FAIL fill%0d_resp beat %0d: got %b, required %b", ds, i, ob_resp_hi[i], e_resp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    dut_sel = 1'b0;
    set_tr(0, 1'b1, 16'h0010, 1'b1, 3'b010, 32'hDEADBEEF, 2'b10);
    set_tr(1, 1'b1, 16'h0010, 1'b0, 3'b010, 32'h0,        2'b10);
    set_tr(2, 1'b1, 16'h0012, 1'b1, 3'b001, 32'hABCD0000, 2'b10);
    set_tr(3, 1'b1, 16'h0010, 1'b0, 3'b010, 32'h0,        2'b10);
    set_tr(4, 1'b1, 16'h0011, 1'b1, 3'b000, 32'h00005500, 2'b10);
    set_tr(5, 1'b1, 16'h0010, 1'b0, 3'b010, 32'h0,        2'b10);
    compute_exp(6, 0);
    run_bus(6);
    for (int i = 0; i < 6; i++) begin
      checks += 3;
      if (ob_waits[i] !== e_waits[i]) begin errors++; $display("FAIL b2b_waits beat %0d: got %0d, required %0d", i, ob_waits[i], e_waits[i]); end
      if (ob_resp_hi[i] !== e_resp[i]) begin errors++; $display("FAIL b2b_resp beat %0d: got %b, required %b", i, ob_resp_hi[i], e_resp[i]); end
      if (ob_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL b2b_rdata beat %0d: got %h, required %h", i, ob_rdata[i], e_rdata[i]); end
    end
    checks += 3;
    if (ob_rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_readback: got %h, required deadbeef", ob_rdata[1]); end
    if (ob_rdata[3] !== 32'hABCDBEEF) begin errors++; $display("FAIL half_readback: got %h, required abcdbeef", ob_rdata[3]); end
    if (ob_rdata[5] !== 32'hABCD55EF) begin errors++; $display("FAIL byte_readback: got %h, required abcd55ef", ob_rdata[5]); end
  endtask

  task automatic test_burst_waits;
    dut_sel = 1'b1;
    for (int i = 0; i < 4; i++)
      set_tr(i, 1'b1, 16'(32 + i * 2), 1'b0, 3'b001, 32'h0, (i == 0) ? 2'b10 : 2'b11);
    compute_exp(4, 1);
    run_bus(4);
    for (int i = 0; i < 4; i++) begin
      checks += 4;
      if (ob_waits[i] !== 2) begin errors++; $display("FAIL burst_waits beat %0d: got %0d, required 2", i, ob_waits[i]); end
      if (ob_resp_lo[i] !== 1'b0) begin errors++; $display("FAIL burst_wait_resp beat %0d: got %b, required 0", i, ob_resp_lo[i]); end
      if (ob_resp_hi[i] !== 1'b0) begin errors++; $display("FAIL burst_resp beat %0d: got %b, required 0", i, ob_resp_hi[i]); end
      if (ob_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL burst_rdata beat %0d: got %h, required %h", i, ob_rdata[i], e_rdata[i]); end
    end
    checks++;
    if (ob_done_edge[3] - ob_acc_edge[0] !== 12) begin
      errors++;
      $display("FAIL burst_length: got %0d cycles, required 12", ob_done_edge[3] - ob_acc_edge[0]);
    end
  endtask

  task automatic test_errors;
    dut_sel = 1'b0;
    set_tr(0, 1'b1, 16'h0100, 1'b0, 3'b010, 32'h0,        2'b10);
    set_tr(1, 1'b1, 16'h0011, 1'b1, 3'b001, 32'h12345678, 2'b10);
    set_tr(2, 1'b1, 16'h0010, 1'b0, 3'b010, 32'h0,        2'b10);
    set_tr(3, 1'b1, 16'h0000, 1'b0, 3'b011, 32'h0,        2'b10);
    set_tr(4, 1'b1, 16'h0002, 1'b1, 3'b010, 32'hCAFEF00D, 2'b10);
    set_tr(5, 1'b1, 16'h0000, 1'b0, 3'b010, 32'h0,        2'b10);
    compute_exp(6, 0);
    run_bus(6);
    for (int i = 0; i < 6; i++) begin
      checks += 4;
      if (ob_waits[i] !== e_waits[i]) begin errors++; $display("FAIL err_waits beat %0d: got %0d, required %0d", i, ob_waits[i], e_waits[i]); end
      if (ob_resp_lo[i] !== e_resp[i]) begin errors++; $display("FAIL err_resp_first beat %0d: got %b, required %b", i, ob_resp_lo[i], e_resp[i]); end
      if (ob_resp_hi[i] !== e_resp[i]) begin errors++; $display("FAIL err_resp_last beat %0d: got %b, required %b", i, ob_resp_hi[i], e_resp[i]); end
      if (ob_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL err_rdata beat %0d: got %h, required %h", i, ob_rdata[i], e_rdata[i]); end
    end
  endtask

  task automatic test_hsel_reset;
    // deselected write must not land
    dut_sel = 1'b0;
    set_tr(0, 1'b0, 16'h0040, 1'b1, 3'b010, 32'h5A5A5A5A, 2'b10);
    set_tr(1, 1'b1, 16'h0040, 1'b0, 3'b010, 32'h0,        2'b10);
    compute_exp(2, 0);
    run_bus(2);
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (ob_waits[i] !== e_waits[i]) begin errors++; $display("FAIL hsel_waits beat %0d: got %0d, required %0d", i, ob_waits[i], e_waits[i]); end
      if (ob_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL hsel_rdata beat %0d: got %h, required %h", i, ob_rdata[i], e_rdata[i]); end
    end

    // reset during the first wait cycle of a write to 0x0030
    dut_sel = 1'b1;
    hsel_bus = 1'b1; haddr = 16'h0030; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge HCLK); #1;
    present(0, 0);
    hwdata = 32'h12345678;
    @(negedge HCLK);
    checks++;
    if (hready_bus !== 1'b0) begin errors++; $display("FAIL midrst_wait: got ready %b, required 0", hready_bus); end
    RESET = 1'b1;
    @(posedge HCLK); #1;
    RESET = 1'b0;
    @(negedge HCLK);
    checks += 3;
    if (hready_bus !== 1'b1)   begin errors++; $display("FAIL midrst_ready: got %b, required 1", hready_bus); end
    if (hresp_bus !== 1'b0)    begin errors++; $display("FAIL midrst_resp: got %b, required 0", hresp_bus); end
    if (hrdata_bus !== 32'h0)  begin errors++; $display("FAIL midrst_rdata: got %h, required 0", hrdata_bus); end
    @(posedge HCLK); #1;
    set_tr(0, 1'b1, 16'h0030, 1'b0, 3'b010, 32'h0, 2'b10);
    compute_exp(1, 1);
    run_bus(1);
    checks += 2;
    if (ob_waits[0] !== 2) begin errors++; $display("FAIL midrst_read_waits: got %0d, required 2", ob_waits[0]); end
    if (ob_rdata[0] !== e_rdata[0]) begin errors++; $display("FAIL midrst_old_value: got %h, required %h", ob_rdata[0], e_rdata[0]); end
  endtask

  task automatic test_random(input int ds);
    int unsigned a;
    logic [2:0]  sz;
    dut_sel = ds[0];
    for (int i = 0; i < 48; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = $urandom_range(0, 271);
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0)
        a = a & ~((32'd1 << sz) - 1);
      set_tr(i, ($urandom_range(0, 9) != 0), 16'(a), 1'($urandom_range(0, 1)), sz,
             $urandom, (i == 0 || $urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
    end
    compute_exp(48, ds);
    run_bus(48);
    for (int i = 0; i < 48; i++) begin
      checks += 4;
      if (ob_waits[i] !== e_waits[i]) begin errors++; $display("FAIL rand%0d_waits beat %0d: got %0d, required %0d", ds, i, ob_waits[i], e_waits[i]); end
      if (ob_resp_lo[i] !== e_resp[i]) begin errors++; $display("FAIL rand%0d_resp_first beat %0d: got %b, required %b", ds, i, ob_resp_lo[i], e_resp[i]); end
      if (ob_resp_hi[i] !== e_resp[i]) begin errors++; $display("FAIL rand%0d_resp_last beat %0d: got %b, required %b", ds, i, ob_resp_hi[i], e_resp[i]); end
      if (ob_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL rand%0d_rdata beat %0d: got %h, required %h", ds, i, ob_rdata[i], e_rdata[i]); end
    end
    // read every word back to catch stray lane writes
    for (int i = 0; i < 64; i++)
      set_tr(i, 1'b1, 16'(i * 4), 1'b0, 3'b010, 32'h0, (i == 0) ? 2'b10 : 2'b11);
    compute_exp(64, ds);
    run_bus(64);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (ob_rdata[i] !== e_rdata[i]) begin errors++; $display("FAIL rand%0d_sweep word %0d: got %h, required %h", ds, i, ob_rdata[i], e_rdata[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_fill(0);
    test_fill(1);
    test_back_to_back();
    test_burst_waits();
    test_errors();
    test_hsel_reset();
    test_random(0);
    test_random(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
